// File: rtl/cnn_pkg.sv
// Shared types for the CNN datapath: opaque single-precision float words and sequence ids.
package cnn_pkg;

  localparam int unsigned FLOAT_W = 32;
  localparam int unsigned ID_W    = 8;

  typedef logic [FLOAT_W-1:0] float_t;
  typedef logic [ID_W-1:0]    id_t;

  localparam float_t FLOAT_ZERO = 32'h0;

endpackage

// File: rtl/ip_vector_loader_if.sv
// Element stream in, packed vector stream out, for the inner-product vector loader.
interface ip_vector_loader_if #(
  parameter int unsigned WIDTH = 8
) ();
  import cnn_pkg::*;

  float_t             s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  float_t [WIDTH-1:0] out_data;
  id_t                out_id;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  s_data, s_valid, s_last, out_ready,
    output s_ready, out_data, out_id, out_valid
  );

  modport master (
    output s_data, s_valid, s_last, out_ready,
    input  s_ready, out_data, out_id, out_valid
  );

endinterface

// File: rtl/ip_vector_loader.sv
// Packs a serial float stream into WIDTH-lane vectors tagged with a sequence id.
// A fill buffer and an output buffer let the next vector fill while one is held.
module ip_vector_loader
  import cnn_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter id_t         ID_INIT = 8'h00
) (
  input  logic                clk,
  input  logic                reset,
  ip_vector_loader_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [0:0] ST_FILLING = 1'b0;
  localparam logic [0:0] ST_FULL    = 1'b1;

  logic [0:0]         state_q, state_d;
  cnt_t               cnt_q, cnt_d;
  float_t [WIDTH-1:0] fill_q, fill_d;

  float_t [WIDTH-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  id_t                out_id_q, out_id_d;
  id_t                id_cnt_q, id_cnt_d;

  logic               s_ready_c;
  logic               in_fire;
  logic               out_fire;
  logic               out_free;
  logic               copy;
  cnt_t               fill_len;
  logic [WIDTH-1:0]   pad_mask;
  float_t [WIDTH-1:0] merged;
  float_t [WIDTH-1:0] copy_vec;

  // Nothing is accepted or consumed while reset is held.
  assign s_ready_c = (state_q == ST_FILLING) && !reset;
  assign in_fire   = bus.s_valid && s_ready_c;
  assign out_fire  = out_valid_q && bus.out_ready && !reset;
  assign out_free  = !out_valid_q || out_fire;

  // Fill buffer with the incoming element merged in, then zero-padded past the vector length.
  always_comb begin
    merged   = fill_q;
    fill_len = cnt_q;
    pad_mask = '0;
    copy_vec = '0;
    if (in_fire) begin
      fill_len = cnt_q + cnt_t'(1);
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (cnt_t'(i) == cnt_q) merged[i] = bus.s_data;
      end
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pad_mask[i] = (cnt_t'(i) < fill_len);
      copy_vec[i] = pad_mask[i] ? merged[i] : FLOAT_ZERO;
    end
  end

  // Fill FSM next state and copy decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    copy    = 1'b0;
    case (state_q)
      ST_FILLING: begin
        if (in_fire) begin
          fill_d = merged;
          cnt_d  = cnt_q + cnt_t'(1);
          if ((cnt_d == cnt_t'(WIDTH)) || bus.s_last) begin
            if (out_free) begin
              copy  = 1'b1;
              cnt_d = '0;
            end else begin
              state_d = ST_FULL;
            end
          end
        end
      end
      ST_FULL: begin
        if (out_free) begin
          copy    = 1'b1;
          cnt_d   = '0;
          state_d = ST_FILLING;
        end
      end
      default: state_d = ST_FILLING;
    endcase
  end

  // Output buffer and id counter next state.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    id_cnt_d    = id_cnt_q;
    if (copy) begin
      out_data_d  = copy_vec;
      out_valid_d = 1'b1;
      out_id_d    = id_cnt_q;
      id_cnt_d    = id_cnt_q + id_t'(1);
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILLING;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= ID_INIT;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) id_cnt_q <= ID_INIT;
    else       id_cnt_q <= id_cnt_d;
  end

  assign bus.s_ready   = s_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_ip_vector_loader.sv
// Scoreboard bench for ip_vector_loader: a reference packer queues expected vectors on
// accepted inputs and a negedge monitor checks every output transfer against them.
module tb_ip_vector_loader;
  import cnn_pkg::*;

  localparam int unsigned W       = 8;
  localparam int unsigned VW      = 32 * W;
  localparam id_t         ID_INIT = 8'h00;

  typedef struct packed {
    logic [VW-1:0] data;
    id_t           id;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ip_vector_loader_if #(.WIDTH(W)) bus ();

  ip_vector_loader #(.WIDTH(W), .ID_INIT(ID_INIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        sb_q[$];
  exp_t        mon_e;
  float_t      mdl_lane[W];
  int unsigned mdl_cnt;
  id_t         mdl_id;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          stalls = 0;

  float_t t1_vals[8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                         32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  float_t t6_vals[9] = '{32'h7FC00001, 32'h00000001, 32'hFF800000, 32'h80000000,
                         32'h3F800000, 32'h7F800000, 32'h007FFFFF, 32'hC2C80000,
                         32'h12345678};

  task automatic check_eq(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference packer: closes on WIDTH elements or s_last, zero-pads short vectors.
  function automatic void model_accept(input float_t d, input logic last);
    logic [VW-1:0] v;
    mdl_lane[mdl_cnt] = d;
    mdl_cnt++;
    if (mdl_cnt == W || last) begin
      v = '0;
      for (int unsigned i = 0; i < mdl_cnt; i++) v[i*32 +: 32] = mdl_lane[i];
      sb_q.push_back('{data: v, id: mdl_id});
      mdl_id  = mdl_id + id_t'(1);
      mdl_cnt = 0;
    end
  endfunction

  function automatic void model_reset();
    sb_q.delete();
    mdl_cnt = 0;
    mdl_id  = ID_INIT;
  endfunction

  // A transfer happens at the next posedge when valid and ready are both high at the negedge.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_vector", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("out_data", bus.out_data, mon_e.data);
        check_eq("out_id", bus.out_id, mon_e.id);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the element was accepted.
  task automatic send(input float_t d, input logic last);
    int unsigned waited = 0;
    bit          acc    = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!acc) begin
      @(negedge clk);
      if (bus.s_ready) begin
        acc = 1'b1;
        model_accept(d, last);
      end else begin
        waited++;
      end
      @(posedge clk); #1;
      if (!acc && waited > 200) begin
        check_eq("send_timeout", 1, 0);
        acc = 1'b1;
      end
    end
    stalls += int'(waited);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_s_ready", bus.s_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_id", bus.out_id, ID_INIT);
    check_eq("rst_s_ready_after", bus.s_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.s_last    = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();

    // Power-on reset
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("por_s_ready", bus.s_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("por_s_ready_after", bus.s_ready, 1);
    check_eq("por_out_valid", bus.out_valid, 0);
    check_eq("por_out_id", bus.out_id, ID_INIT);
    check_eq("por_out_data", bus.out_data, '0);
    @(posedge clk); #1;

    // 1: full vector without s_last, one-cycle latency
    bus.out_ready = 1'b1;
    foreach (t1_vals[i]) send(t1_vals[i], 1'b0);
    @(negedge clk);
    check_eq("t1_latency", bus.out_valid, 1);
    @(posedge clk); #1;

    // 2: short vector closed by s_last, zero padded
    send(32'h40000000, 1'b0);
    send(32'h40800000, 1'b0);
    send(32'hBF800000, 1'b1);
    idle(4);
    check_eq("t2_drained", sb_q.size(), 0);

    // 3: output stalled, both buffers fill, s_ready drops after 16 elements
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(float_t'(32'h1000 + i), 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = float_t'(32'h1000 + 16);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("t3_s_ready_low", bus.s_ready, 0);
      check_eq("t3_held_valid", bus.out_valid, 1);
      check_eq("t3_held_id", bus.out_id, sb_q[0].id);
      check_eq("t3_held_data", bus.out_data, sb_q[0].data);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    for (int i = 16; i < 24; i++) send(float_t'(32'h1000 + i), 1'b0);
    idle(4);
    check_eq("t3_drained", sb_q.size(), 0);

    // 4: 260 back-to-back vectors, id wraps, no stalls
    do_reset();
    bus.out_ready = 1'b1;
    stalls = 0;
    for (int v = 0; v < 260; v++)
      for (int l = 0; l < 8; l++) send(float_t'($urandom), 1'b0);
    check_eq("t4_no_stall", stalls, 0);
    idle(3);
    check_eq("t4_drained", sb_q.size(), 0);
    check_eq("t4_last_id", bus.out_id, 8'd3);

    // 5: reset mid-vector while vector id 7 is held
    for (int i = 0; i < 24; i++) send(float_t'(32'h2000 + i), 1'b0);
    idle(2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 13; i++) send(float_t'(32'h3000 + i), 1'b0);
    @(negedge clk);
    check_eq("t5_held_id", bus.out_id, 8'd7);
    check_eq("t5_held_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(float_t'(32'hA0000000 + i), 1'b0);
    idle(3);
    check_eq("t5_drained", sb_q.size(), 0);

    // 6: s_last on element 8 of 9; opaque NaN/denormal patterns
    foreach (t6_vals[i]) send(t6_vals[i], (i == 7) || (i == 8));
    idle(4);
    check_eq("t6_drained", sb_q.size(), 0);
    check_eq("t6_out_idle", bus.out_valid, 0);
    check_eq("t6_last_id", bus.out_id, 8'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
